// File: rtl/keypad_entry_pkg.sv
// Shared types and constants for the keypad entry block.
// Key codes, entry FSM state, digit classification.
package keypad_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam logic [3:0] KEY_BKSP  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT_LOW
    } entry_state_e;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'hD;
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Key-in and value-out handshake bundle for keypad_entry.
// master = scanner/consumer side, slave = keypad_entry.
interface keypad_entry_if #(
    parameter int DIGITS = 4
);
    logic [3:0]          key_in;
    logic                key_ready;
    logic                key_ack;
    logic [4*DIGITS-1:0] entry;
    logic [3:0]          digit_count;
    logic                overflow;
    logic [4*DIGITS-1:0] out_value;
    logic                out_valid;
    logic                out_accept;

    modport master (
        output key_in,
        output key_ready,
        input  key_ack,
        input  entry,
        input  digit_count,
        input  overflow,
        input  out_value,
        input  out_valid,
        output out_accept
    );

    modport slave (
        input  key_in,
        input  key_ready,
        output key_ack,
        output entry,
        output digit_count,
        output overflow,
        output out_value,
        output out_valid,
        input  out_accept
    );
endinterface

// File: rtl/keypad_entry_buf.sv
// Entry digit shift register with push/pop/clear strobes.
// KEYPAD_ENTRY_ROLL_EN: push on full shifts anyway, dropping the oldest nibble.
module keypad_entry_buf
    import keypad_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic                clear,
    input  logic [3:0]          din,
    output logic [4*DIGITS-1:0] entry,
    output logic [3:0]          count,
    output logic                full,
    output logic                empty
);

    localparam int         W   = 4 * DIGITS;
    localparam logic [3:0] MAX = 4'(DIGITS);

    logic [W-1:0] entry_q, entry_d;
    logic [3:0]   count_q, count_d;
    logic [W-1:0] shifted;

    assign shifted = (entry_q << 4) | W'(din);
    assign full    = (count_q == MAX);
    assign empty   = (count_q == 4'd0);

    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        if (clear) begin
            entry_d = '0;
            count_d = 4'd0;
        end else if (push) begin
            if (!full) begin
                entry_d = shifted;
                count_d = count_q + 4'd1;
            end else begin
`ifdef KEYPAD_ENTRY_ROLL_EN
                entry_d = shifted;
`else
                entry_d = entry_q;
`endif
            end
        end else if (pop && !empty) begin
            entry_d = entry_q >> 4;
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
            count_q <= 4'd0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

    assign entry = entry_q;
    assign count = count_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry assembler: consumes scanner keys, builds a hex entry,
// presents it on enter. Option macro KEYPAD_ENTRY_ROLL_EN (see buffer).
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    keypad_entry_if.slave  bus
);

    localparam int W = 4 * DIGITS;

    entry_state_e state_q, state_d;
    logic         overflow_q, overflow_d;
    logic [W-1:0] out_value_q, out_value_d;
    logic         out_valid_q, out_valid_d;

    logic         push, pop, clear;
    logic [W-1:0] entry;
    logic [3:0]   count;
    logic         full, empty;

    keypad_entry_buf #(.DIGITS(DIGITS)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (bus.key_in),
        .entry (entry),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d     = state_q;
        push        = 1'b0;
        pop         = 1'b0;
        clear       = 1'b0;
        overflow_d  = overflow_q;
        out_value_d = out_value_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && bus.out_accept) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                // A pending output blocks key consumption entirely
                if (bus.key_ready && !out_valid_q) begin
                    state_d = ST_ACK;
                    unique case (1'b1)
                        is_digit(bus.key_in): begin
                            push = 1'b1;
                            if (full) overflow_d = 1'b1;
                        end
                        (bus.key_in == KEY_BKSP): begin
                            pop = 1'b1;
                        end
                        (bus.key_in == KEY_ENTER): begin
                            if (!empty) begin
                                out_value_d = entry;
                                out_valid_d = 1'b1;
                                clear       = 1'b1;
                                overflow_d  = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_ACK: begin
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!bus.key_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            overflow_q  <= 1'b0;
            out_value_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            out_value_q <= out_value_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.key_ack     = (state_q == ST_ACK);
    assign bus.entry       = entry;
    assign bus.digit_count = count;
    assign bus.overflow    = overflow_q;
    assign bus.out_value   = out_value_q;
    assign bus.out_valid   = out_valid_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed-vector bench for keypad_entry (DIGITS=4).
// Honours KEYPAD_ENTRY_ROLL_EN for the overflow expectation.
module tb_keypad_entry;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   ack_cnt;
    int   base;

`ifdef KEYPAD_ENTRY_ROLL_EN
    localparam logic [15:0] EXP_FULL = 16'h2345;
`else
    localparam logic [15:0] EXP_FULL = 16'h1234;
`endif

    keypad_entry_if #(.DIGITS(4)) bus ();

    keypad_entry #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.key_ack) ack_cnt++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        while (bus.key_ack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.key_ack), 32'd1);
    endtask

    task automatic press(input logic [3:0] k);
        @(posedge clk);
        #1;
        bus.key_in    = k;
        bus.key_ready = 1'b1;
        wait_ack("ack_seen");
        @(posedge clk);
        #1;
        bus.key_ready = 1'b0;
        repeat (2) @(posedge clk);
        settle();
    endtask

    task automatic accept();
        @(posedge clk);
        #1;
        bus.out_accept = 1'b1;
        @(posedge clk);
        #1;
        bus.out_accept = 1'b0;
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        ack_cnt        = 0;
        rst_n          = 1'b0;
        bus.key_in     = 4'h0;
        bus.key_ready  = 1'b0;
        bus.out_accept = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        settle();

        chk("rst_entry", 32'(bus.entry), 32'h0);
        chk("rst_count", 32'(bus.digit_count), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_oval", 32'(bus.out_value), 32'h0);
        chk("rst_ovalid", 32'(bus.out_valid), 32'd0);
        chk("rst_ack", 32'(bus.key_ack), 32'd0);

        // 1,2,3,A then enter
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'hA);
        chk("t1_entry", 32'(bus.entry), 32'h123A);
        chk("t1_count", 32'(bus.digit_count), 32'd4);
        chk("t1_acks", 32'(ack_cnt), 32'd4);
        press(4'hE);
        chk("t1_ovalid", 32'(bus.out_valid), 32'd1);
        chk("t1_oval", 32'(bus.out_value), 32'h123A);
        chk("t1_entry0", 32'(bus.entry), 32'h0);
        chk("t1_count0", 32'(bus.digit_count), 32'd0);
        chk("t1_acks5", 32'(ack_cnt), 32'd5);
        accept();
        settle();
        chk("t1_accepted", 32'(bus.out_valid), 32'd0);

        // backspace on empty, then 5,6,F,7
        base = ack_cnt;
        press(4'hF);
        chk("t2_bs0_ack", 32'(ack_cnt), 32'(base + 1));
        chk("t2_bs0_entry", 32'(bus.entry), 32'h0);
        chk("t2_bs0_count", 32'(bus.digit_count), 32'd0);
        press(4'h5);
        press(4'h6);
        press(4'hF);
        chk("t2_bs_entry", 32'(bus.entry), 32'h5);
        press(4'h7);
        chk("t2_entry", 32'(bus.entry), 32'h57);
        chk("t2_count", 32'(bus.digit_count), 32'd2);
        press(4'hE);
        chk("t2_oval", 32'(bus.out_value), 32'h57);
        accept();

        // enter on empty is ignored
        press(4'hE);
        chk("t2_enter0", 32'(bus.out_valid), 32'd0);

        // overflow
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        chk("t3_noovf", 32'(bus.overflow), 32'd0);
        press(4'h5);
        chk("t3_entry", 32'(bus.entry), 32'(EXP_FULL));
        chk("t3_count", 32'(bus.digit_count), 32'd4);
        chk("t3_ovf", 32'(bus.overflow), 32'd1);
        press(4'hE);
        chk("t3_oval", 32'(bus.out_value), 32'(EXP_FULL));
        chk("t3_ovf_clr", 32'(bus.overflow), 32'd0);

        // back-pressure: out_valid held, key 9 waiting
        base = ack_cnt;
        @(posedge clk);
        #1;
        bus.key_in    = 4'h9;
        bus.key_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("t5_noack", 32'(ack_cnt), 32'(base));
        chk("t5_held", 32'(bus.out_valid), 32'd1);
        accept();
        chk("t5_vfall", 32'(bus.out_valid), 32'd0);
        chk("t5_noack_same", 32'(bus.key_ack), 32'd0);
        wait_ack("t5_ack");
        @(posedge clk);
        #1;
        bus.key_ready = 1'b0;
        repeat (2) @(posedge clk);
        settle();
        chk("t5_entry", 32'(bus.entry), 32'h9);
        chk("t5_acks", 32'(ack_cnt), 32'(base + 1));

        // ready held 10 cycles after ack: one key only
        base = ack_cnt;
        @(posedge clk);
        #1;
        bus.key_in    = 4'h3;
        bus.key_ready = 1'b1;
        wait_ack("t4_ack");
        repeat (10) @(negedge clk);
        #1;
        chk("t4_once", 32'(ack_cnt), 32'(base + 1));
        chk("t4_entry", 32'(bus.entry), 32'h93);
        @(posedge clk);
        #1;
        bus.key_ready = 1'b0;
        repeat (2) @(posedge clk);
        press(4'h4);
        chk("t4_next", 32'(bus.entry), 32'h934);
        chk("t4_count", 32'(bus.digit_count), 32'd3);
        chk("t4_acks", 32'(ack_cnt), 32'(base + 2));

        // reset while waiting for ready to drop
        @(posedge clk);
        #1;
        bus.key_in    = 4'h8;
        bus.key_ready = 1'b1;
        wait_ack("t6_ack");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_entry", 32'(bus.entry), 32'h0);
        chk("t6_count", 32'(bus.digit_count), 32'd0);
        chk("t6_ack0", 32'(bus.key_ack), 32'd0);
        chk("t6_ovalid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        base = ack_cnt;
        repeat (10) @(negedge clk);
        #1;
        chk("t6_reack", 32'(ack_cnt), 32'(base + 1));
        chk("t6_entry8", 32'(bus.entry), 32'h8);
        chk("t6_count1", 32'(bus.digit_count), 32'd1);
        bus.key_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
